// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of instr_encoder.
interface instr_encoder_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_fmt;
    logic [6:0]      in_opcode;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic [XLEN-1:0] in_imm;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_addr;
    logic            out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32 fields into R/I/S/B/U/J words behind a 2-entry FIFO with address tags.
// INSTR_ENC_ERR_DROP_EN: errored bundles are counted but dropped instead of emitted.
module instr_encoder #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int              ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_encoder_if.slave       bus,
    input  logic                 addr_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    logic [31:0]     instr_q [2];
    logic [XLEN-1:0] addr_q  [2];
`ifndef INSTR_ENC_ERR_DROP_EN
    logic            err_q   [2];
`endif
    logic            rd_ptr, wr_ptr;
    logic [1:0]      count;
    logic [XLEN-1:0] addr_cnt;
    logic [XLEN-1:0] push_tag;
    logic [31:0]     enc_instr;
    logic            enc_err;
    logic            accept, push, pop;
    logic [XLEN-1:0] imm;

    // True when v is representable as a two's-complement value of 'bits' bits.
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
        logic signed [XLEN-1:0] sh;
        sh = $signed(v) >>> (bits - 1);
        return (sh == '0) || (sh == '1);
    endfunction

    assign imm = bus.in_imm;

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
        case (fmt_e'(bus.in_fmt))
            FMT_R: enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_rd, bus.in_opcode};
            FMT_I: begin
                enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                enc_err   = !fits_signed(imm, 12);
            end
            FMT_S: begin
                enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:0], bus.in_opcode};
                enc_err   = !fits_signed(imm, 12);
            end
            FMT_B: begin
                enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                             imm[4:1], imm[11], bus.in_opcode};
                enc_err   = !fits_signed(imm, 13) || imm[0];
            end
            FMT_U: begin
                enc_instr = {imm[31:12], bus.in_rd, bus.in_opcode};
                enc_err   = (imm[11:0] != '0);
            end
            FMT_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
                enc_err   = !fits_signed(imm, 21) || imm[0];
            end
            default: begin
                enc_instr = '0;
                enc_err   = 1'b1;
            end
        endcase
    end

    assign bus.in_ready  = (count < 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = instr_q[rd_ptr];
    assign bus.out_addr  = addr_q[rd_ptr];
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign push_tag      = addr_clr ? BASE_ADDR : addr_cnt;

`ifdef INSTR_ENC_ERR_DROP_EN
    assign push        = accept & ~enc_err;
    assign bus.out_err = 1'b0;
`else
    assign push        = accept;
    assign bus.out_err = err_q[rd_ptr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                instr_q[i] <= '0;
                addr_q[i]  <= BASE_ADDR;
`ifndef INSTR_ENC_ERR_DROP_EN
                err_q[i]   <= 1'b0;
`endif
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
            addr_cnt <= BASE_ADDR;
            err_cnt  <= '0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= enc_instr;
                addr_q[wr_ptr]  <= push_tag;
`ifndef INSTR_ENC_ERR_DROP_EN
                err_q[wr_ptr]   <= enc_err;
`endif
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
            // A clear coincident with a push tags that word with BASE_ADDR and steps past it.
            if (push) begin
                addr_cnt <= push_tag + XLEN'(4);
            end else if (addr_clr) begin
                addr_cnt <= BASE_ADDR;
            end
            if (accept && enc_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Packs decoded RISC-V instruction fields back into 32-bit RV32 instruction words in R/I/S/B/U/J format, the inverse of the instruction decode path. Sits between a test/boot program generator and instruction memory. Fields arrive over a valid/ready input. Encoded words leave through a 2-entry output FIFO, each tagged with a sequential write address and a range-error flag.

Parameters:
XLEN, 32, data/address width of out_addr and in_imm
BASE_ADDR, 32'h0000_0000, address of first emitted word and value restored by addr_clr
ERR_CNT_W, 16, width of saturating error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6-7 illegal
in_opcode  in  7  opcode field, copied to bits[6:0]
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  XLEN  signed byte-offset immediate (U: full upper value)
out_valid  out  1  encoded word valid
out_ready  in  1  sink accepts word
out_instr  out  32  encoded instruction
out_addr  out  XLEN  write address of out_instr
out_err  out  1  immediate out of range or illegal fmt
addr_clr  in  1  reload address counter to BASE_ADDR
err_cnt  out  ERR_CNT_W  count of errored bundles, saturating

Behaviour:
- Reset (async, rst_n=0): FIFO empty, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0, in_ready=1 after release.
- Accept when in_valid & in_ready. Encoding is combinational on in_* and is pushed into the FIFO at the accept edge. Latency is 1 cycle: out_valid rises on the next cycle if the FIFO was empty.
- in_ready = (fifo_count < 2). It depends only on registered count, never combinationally on out_ready.
- Output pop occurs when out_valid & out_ready. Simultaneous push and pop with count=1 keeps count=1; with count=2 no push occurs.
- out_* show the FIFO head and hold stable while out_valid & !out_ready.
- Formats:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Range checks set err:
  - I/S: imm must fit signed 12 bits.
  - B: imm must fit signed 13 bits and imm[0]=0.
  - J: imm must fit signed 21 bits and imm[0]=0.
  - U: imm[11:0] must be 0.
  - fmt 6-7: always err, instr=0.
  - R: never errs on imm; imm is ignored.
  - An errored word carries truncated fields per the format.
- Address counter:
  - out_addr is assigned at push time from a push counter: the first word gets BASE_ADDR, and each successful push adds 4, wrapping modulo 2^XLEN.
  - addr_clr reloads the counter to BASE_ADDR. Words already in the FIFO keep their tags.
  - addr_clr coincident with a push: the pushed word gets BASE_ADDR, and the counter becomes BASE_ADDR+4.
- err_cnt increments once per accepted errored bundle and saturates at all-ones.

Optional Feature:
Macro INSTR_ENC_ERR_DROP_EN.
- Defined: errored bundles are accepted (in_ready unchanged) and counted in err_cnt, but not pushed; the address counter does not advance, and out_err is tied 0.
- Undefined: errored bundles are pushed with out_err=1 and consume an address.

Test Plan:
- Reset, then I-type opcode=0x13, rd=1, rs1=0, f3=0, imm=5 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0x0, out_err=0.
- S-type opcode=0x23, rs1=1, rs2=2, f3=2, imm=8, then B-type opcode=0x63, rs1=0, rs2=0, f3=0, imm=-4 (out_ready=1) -> 0x0020A423 @0x0, then 0xFE000EE3 @0x4.
- J-type opcode=0x6F, rd=1, imm=0x800, then U-type opcode=0x37, rd=5, imm=0x12345000 -> 0x001000EF, 0x123452B7, addresses +4 apart.
- out_ready=0, push 3 bundles -> in_ready=0 after 2, third held. Raise out_ready -> 3 words in order, addresses 0x0, 0x4, 0x8.
- I-type imm=2048, then B-type imm=3 -> err_cnt=2. Without macro: out_err=1 on both. With macro: no out_valid and next good word at 0x0.
- Assert addr_clr with a push after 3 words -> pushed word has out_addr=BASE_ADDR. Assert rst_n=0 mid-stream with 2 words queued -> out_valid=0 immediately, err_cnt=0.
